// File: rtl/crg_rst_seq_pkg.sv
// crg_rst_seq_pkg
// Shared definitions for the CRG reset-release sequencer:
//   - state_e      : sequencer FSM state encoding
//   - DEF_NUM_STG  : default number of sequenced reset outputs
//   - DEF_CNT_W    : default width of a per-stage delay field / counter
//   - DEF_MIN_ASSERT : default request-free cycles before the first release
package crg_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  localparam int DEF_NUM_STG    = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_MIN_ASSERT = 8;

endpackage

// File: rtl/crg_sync2_arst.sv
// crg_sync2_arst
// Two-flop synchronizer for a single level signal, with an asynchronous
// active-low clear.
// Ports:
//   clk   : destination clock
//   clr_n : asynchronous clear, active-low (forces q to 0)
//   d     : asynchronous input level
//   q     : synchronized output, two clk edges behind d
module crg_sync2_arst (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/crg_rst_seq.sv
// crg_rst_seq
// Reset-release sequencer. Holds every downstream reset asserted while a
// request is present, then, after MIN_ASSERT request-free cycles, releases
// the stages one at a time in index order with a programmable per-stage gap.
// Ports:
//   clk       : single clock, all logic on posedge
//   rst       : synchronous active-high reset (same effect as power-on)
//   rst_req   : synchronous software reset request, level, active-high
//   ext_req   : asynchronous external reset request, level, active-high
//   dly_cfg   : per-stage release delay, field k = [k*CNT_W +: CNT_W]
//   stg_rst_n : per-stage reset, active-low, registered
//   seq_busy  : high while asserting or releasing
//   seq_done  : high once every stage is released
//   cur_stg   : stage currently counting its delay; 0 outside release
module crg_rst_seq
  import crg_rst_seq_pkg::*;
#(
  parameter int NUM_STG    = DEF_NUM_STG,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int MIN_ASSERT = DEF_MIN_ASSERT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rst_req,
  input  logic                       ext_req,
  input  logic [NUM_STG*CNT_W-1:0]   dly_cfg,
  output logic [NUM_STG-1:0]         stg_rst_n,
  output logic                       seq_busy,
  output logic                       seq_done,
  output logic [$clog2(NUM_STG)-1:0] cur_stg
);

  localparam int STG_W = $clog2(NUM_STG);

  state_e                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [STG_W-1:0]         k_q;
  logic [NUM_STG*CNT_W-1:0] dly_q;
  logic [1:0]               mask_q;
  logic                     ext_req_s;
  logic                     req;
  logic [CNT_W-1:0]         cur_dly;

  crg_sync2_arst u_ext_sync (
    .clk   (clk),
    .clr_n (1'b1),
    .d     (ext_req),
    .q     (ext_req_s)
  );

  // The synchronizer has no reset, so its contents are unknown for the
  // first two cycles after rst falls; treat them as an active request.
  assign req     = rst_req | ext_req_s | (|mask_q);
  assign cur_dly = dly_q[k_q*CNT_W +: CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      k_q       <= '0;
      dly_q     <= '0;
      mask_q    <= 2'b11;
      stg_rst_n <= '0;
      seq_busy  <= 1'b1;
      seq_done  <= 1'b0;
      cur_stg   <= '0;
    end else begin
      mask_q <= {mask_q[0], 1'b0};
      case (state_q)
        ST_ASSERT: begin
          stg_rst_n <= '0;
          seq_busy  <= 1'b1;
          seq_done  <= 1'b0;
          cur_stg   <= '0;
          if (req) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(MIN_ASSERT - 1)) begin
            // Delays are frozen here so later dly_cfg edits cannot disturb
            // a sequence already in progress.
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
            k_q     <= '0;
            dly_q   <= dly_cfg;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (req) begin
            // A new request wins over a release due in the same cycle.
            state_q   <= ST_ASSERT;
            stg_rst_n <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            cur_stg   <= '0;
            seq_busy  <= 1'b1;
            seq_done  <= 1'b0;
          end else if (cnt_q == cur_dly) begin
            // Counter restarts on the match, so it never wraps even for
            // the maximum delay value.
            stg_rst_n[k_q] <= 1'b1;
            cnt_q          <= '0;
            if (k_q == STG_W'(NUM_STG - 1)) begin
              state_q  <= ST_DONE;
              k_q      <= '0;
              cur_stg  <= '0;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              k_q     <= k_q + 1'b1;
              cur_stg <= k_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_DONE: begin
          if (req) begin
            state_q   <= ST_ASSERT;
            stg_rst_n <= '0;
            cnt_q     <= '0;
            k_q       <= '0;
            cur_stg   <= '0;
            seq_busy  <= 1'b1;
            seq_done  <= 1'b0;
          end
        end

        default: begin
          // Unreachable encoding: fall back to holding everything in reset.
          state_q   <= ST_ASSERT;
          stg_rst_n <= '0;
          cnt_q     <= '0;
          k_q       <= '0;
          cur_stg   <= '0;
          seq_busy  <= 1'b1;
          seq_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crg_rst_seq.sv
// tb_crg_rst_seq
// Checks crg_rst_seq against a closed-form model: the sequencer's outputs
// depend only on how many consecutive request-free edges have been seen
// (idle) and on the delays captured when idle first reaches MIN_ASSERT.
// Stage k is released once idle >= MIN_ASSERT + sum_{j<=k}(dly[j]+1).
module tb_crg_rst_seq;
  import crg_rst_seq_pkg::*;

  localparam int NUM_STG    = DEF_NUM_STG;
  localparam int CNT_W      = DEF_CNT_W;
  localparam int MIN_ASSERT = DEF_MIN_ASSERT;
  localparam int STG_W      = $clog2(NUM_STG);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                     rst_req = 1'b0;
  logic                     ext_req = 1'b0;
  logic [NUM_STG*CNT_W-1:0] dly_cfg = '0;
  logic [NUM_STG-1:0]       stg_rst_n;
  logic                     seq_busy;
  logic                     seq_done;
  logic [STG_W-1:0]         cur_stg;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   idle      = 0;
  int   since_rst = 0;
  logic ext_d1    = 1'b0;
  logic ext_d2    = 1'b0;
  int   dly_m [NUM_STG];

  crg_rst_seq #(
    .NUM_STG    (NUM_STG),
    .CNT_W      (CNT_W),
    .MIN_ASSERT (MIN_ASSERT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rst_req   (rst_req),
    .ext_req   (ext_req),
    .dly_cfg   (dly_cfg),
    .stg_rst_n (stg_rst_n),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .cur_stg   (cur_stg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int thr(input int k);
    int s = MIN_ASSERT;
    for (int j = 0; j <= k; j++) s += dly_m[j] + 1;
    return s;
  endfunction

  // One clock edge: update the model with the inputs the DUT sampled,
  // then compare every output just after the edge.
  task automatic tick();
    logic             ext_s;
    logic             req_s;
    logic [NUM_STG-1:0] e_stg;
    int               rel;
    logic             e_done;
    @(posedge clk);
    ext_s  = ext_d2;
    ext_d2 = ext_d1;
    ext_d1 = ext_req;
    if (rst) begin
      idle      = 0;
      since_rst = 0;
    end else begin
      req_s = rst_req | ext_s | (since_rst < 2);
      if (since_rst < 2) since_rst++;
      if (req_s) idle = 0;
      else begin
        idle++;
        if (idle == MIN_ASSERT)
          for (int k = 0; k < NUM_STG; k++) dly_m[k] = int'(dly_cfg[k*CNT_W +: CNT_W]);
      end
    end
    #1;
    e_stg = '0;
    rel   = 0;
    if (idle >= MIN_ASSERT)
      for (int k = 0; k < NUM_STG; k++)
        if (idle >= thr(k)) begin
          e_stg[k] = 1'b1;
          rel++;
        end
    e_done = (rel == NUM_STG);
    check("stg_rst_n", 32'(stg_rst_n), 32'(e_stg));
    check("seq_done", 32'(seq_done), 32'(e_done));
    check("seq_busy", 32'(seq_busy), 32'(!e_done));
    check("cur_stg", 32'(cur_stg), e_done ? 32'd0 : 32'(rel));
  endtask

  // Ticks until seq_done is seen, bounded; returns the edge count.
  task automatic run_to_done(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!seq_done && n < limit);
  endtask

  initial begin
    int n;
    int sum;
    for (int k = 0; k < NUM_STG; k++) dly_m[k] = 0;

    // Power-on: dly = {3,0,5,1} for k=0..3
    dly_cfg = {8'd1, 8'd5, 8'd0, 8'd3};
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    run_to_done(200, n);
    check("power_on_latency", 32'(n), 32'd23);

    // Mid-sequence abort after stage 1 released
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    n = 0;
    while (!(stg_rst_n[1] && !stg_rst_n[2]) && n < 100) begin tick(); n++; end
    check("abort_reach_k1", 32'(stg_rst_n[1]), 32'd1);
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    check("abort_clear", 32'(stg_rst_n), 32'd0);
    run_to_done(200, n);
    check("abort_restart_latency", 32'(n), 32'd21);

    // External path from DONE
    ext_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (stg_rst_n != '0 && n < 10);
    check("ext_assert_latency", 32'(n), 32'd3);
    repeat (4) tick();
    ext_req = 1'b0;
    run_to_done(200, n);
    check("ext_release_latency", 32'(n), 32'd23);

    // Config shadowing: change to all 255 once RELEASE is entered
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    repeat (MIN_ASSERT + 1) tick();
    dly_cfg = '1;
    run_to_done(200, n);
    check("shadow_old_timing", 32'(n + MIN_ASSERT + 1), 32'd21);
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    run_to_done(2000, n);
    check("shadow_max_delay", 32'(n), 32'(MIN_ASSERT + NUM_STG * 256));

    // Zero delays: one stage per cycle
    dly_cfg = '0;
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    run_to_done(200, n);
    check("zero_delay_latency", 32'(n), 32'(MIN_ASSERT + NUM_STG));

    // Synchronous reset while stage 2 is counting
    dly_cfg = {8'd1, 8'd5, 8'd0, 8'd3};
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    n = 0;
    while (cur_stg != STG_W'(2) && n < 100) begin tick(); n++; end
    check("reach_stg2", 32'(cur_stg), 32'd2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_stg", 32'(stg_rst_n), 32'd0);
    check("rst_mid_cur", 32'(cur_stg), 32'd0);
    check("rst_mid_done", 32'(seq_done), 32'd0);
    run_to_done(200, n);
    check("rst_mid_restart", 32'(n), 32'd23);

    // Randomized requests, resets and config changes
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: begin
          rst_req = 1'b1;
          repeat ($urandom_range(1, 3)) tick();
          rst_req = 1'b0;
        end
        1: begin
          ext_req = 1'b1;
          repeat ($urandom_range(1, 4)) tick();
          ext_req = 1'b0;
        end
        2: begin
          rst = 1'b1;
          repeat ($urandom_range(1, 2)) tick();
          rst = 1'b0;
        end
        default: begin
          for (int k = 0; k < NUM_STG; k++)
            dly_cfg[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 6));
        end
      endcase
      repeat ($urandom_range(0, 45)) tick();
    end

    // Final random sequence run to completion with a computed latency
    for (int k = 0; k < NUM_STG; k++)
      dly_cfg[k*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 9));
    sum = 0;
    for (int k = 0; k < NUM_STG; k++) sum += int'(dly_cfg[k*CNT_W +: CNT_W]);
    rst_req = 1'b1; tick(); rst_req = 1'b0;
    run_to_done(500, n);
    check("random_cfg_latency", 32'(n), 32'(MIN_ASSERT + sum + NUM_STG));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
